// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared encodings and helpers for the seven-segment page scheduler.
//   page_e      : which page the display shows (TIME, DATE, YEAR)
//   mode_e      : scheduler mode (AUTO rotation, MANUAL stepping, EDIT lock)
//   next_page   : rotation order TIME -> DATE -> YEAR -> TIME
//   decode_page : maps the setter's 2-bit page select onto page_e (3 -> TIME)
// -----------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic [1:0] {
        PAGE_TIME = 2'd0,
        PAGE_DATE = 2'd1,
        PAGE_YEAR = 2'd2
    } page_e;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_EDIT   = 2'd2
    } mode_e;

    function automatic page_e next_page(input page_e cur);
        page_e nxt;
        case (cur)
            PAGE_TIME: nxt = PAGE_DATE;
            PAGE_DATE: nxt = PAGE_YEAR;
            default:   nxt = PAGE_TIME;
        endcase
        return nxt;
    endfunction

    function automatic page_e decode_page(input logic [1:0] sel);
        page_e p;
        case (sel)
            2'd1:    p = PAGE_DATE;
            2'd2:    p = PAGE_YEAR;
            default: p = PAGE_TIME;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Seconds counter for page dwell / manual hold timing.
//   clk_100MHz : system clock
//   reset_n    : asynchronous active-low reset
//   clear      : synchronous clear, overrides tick
//   tick       : one-cycle 1 Hz strobe, increments the count
//   limit      : runtime terminal count in seconds (>= 1)
//   expire     : one-cycle pulse on the tick that completes `limit` seconds;
//                the counter wraps to 0 on that same edge
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int unsigned CntW = 4
) (
    input  logic            clk_100MHz,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            tick,
    input  logic [CntW-1:0] limit,
    output logic            expire
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        // >= rather than == so a limit that shrinks under a running count
        // still terminates instead of wrapping the full counter range.
        expire = tick && !clear && (cnt_q >= (limit - CntW'(1)));
        cnt_d  = cnt_q;
        if (clear || expire) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_page_scheduler.sv
// -----------------------------------------------------------------------------
// disp_page_scheduler
// Chooses the page shown on the four-digit seven-segment display and drives
// registered BCD digits plus a per-digit blank mask to the mux driver.
//
// Parameters:
//   DWELL_S : seconds per page in AUTO rotation (>= 1)
//   HOLD_S  : seconds without a button press before MANUAL falls back to AUTO
//
// Ports:
//   clk_100MHz, reset_n          : clock, asynchronous active-low reset
//   tick_1hz, btn_next           : one-cycle strobes (1 Hz tick, next-page button)
//   edit_active, edit_page,
//   edit_field                   : setter status; locks the page and blinks a pair
//   hour/min/day/month/year_bcd  : BCD sources, passed through unchecked
//   dig3..dig0, blank            : registered digits (dig3 leftmost), dark mask
//   page, mode                   : current page and mode encodings
//
// Build option:
//   DISP_LEADING_ZERO_BLANK_EN : when defined, a zero dig3 is darkened on the
//                                TIME and DATE pages.
// -----------------------------------------------------------------------------
module disp_page_scheduler #(
    parameter int unsigned DWELL_S = 5,
    parameter int unsigned HOLD_S  = 10
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        tick_1hz,
    input  logic        btn_next,
    input  logic        edit_active,
    input  logic [1:0]  edit_page,
    input  logic        edit_field,
    input  logic [7:0]  hour_bcd,
    input  logic [7:0]  min_bcd,
    input  logic [7:0]  day_bcd,
    input  logic [7:0]  month_bcd,
    input  logic [15:0] year_bcd,
    output logic [3:0]  dig3,
    output logic [3:0]  dig2,
    output logic [3:0]  dig1,
    output logic [3:0]  dig0,
    output logic [3:0]  blank,
    output logic [1:0]  page,
    output logic [1:0]  mode
);

    import disp_pkg::*;

    localparam int unsigned MaxS = (DWELL_S > HOLD_S) ? DWELL_S : HOLD_S;
    localparam int unsigned CntW = $clog2(MaxS + 1);

    mode_e       mode_q, mode_d;
    page_e       page_q, page_d;
    logic        blink_q, blink_d;
    logic [15:0] dig_q, dig_d;
    logic [3:0]  blank_q, blank_d;

    logic            timer_clear;
    logic            timer_expire;
    logic [CntW-1:0] timer_limit;

    assign timer_limit = (mode_q == MODE_MANUAL) ? CntW'(HOLD_S) : CntW'(DWELL_S);

    dwell_timer #(
        .CntW (CntW)
    ) u_dwell_timer (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .clear      (timer_clear),
        .tick       (tick_1hz),
        .limit      (timer_limit),
        .expire     (timer_expire)
    );

    // Mode/page next state. Priority: edit lock, edit release, button, timer.
    always_comb begin
        mode_d      = mode_q;
        page_d      = page_q;
        blink_d     = blink_q;
        timer_clear = 1'b0;

        if (edit_active) begin
            mode_d      = MODE_EDIT;
            page_d      = decode_page(edit_page);
            timer_clear = 1'b1;
            if (tick_1hz) begin
                blink_d = ~blink_q;
            end
        end else if (mode_q == MODE_EDIT) begin
            // Setter just released: stay on the edited page for a while.
            mode_d      = MODE_MANUAL;
            blink_d     = 1'b0;
            timer_clear = 1'b1;
        end else if (btn_next) begin
            // Button beats a coincident tick; clearing the timer drops the tick.
            mode_d      = MODE_MANUAL;
            page_d      = next_page(page_q);
            timer_clear = 1'b1;
        end else if (timer_expire) begin
            if (mode_q == MODE_MANUAL) begin
                mode_d = MODE_AUTO;
                page_d = PAGE_TIME;
            end else begin
                page_d = next_page(page_q);
            end
        end
    end

    // Output mux works off next state so a page change lands on the digits
    // in the same cycle that page itself updates.
    always_comb begin
        unique case (page_d)
            PAGE_DATE: dig_d = {day_bcd, month_bcd};
            PAGE_YEAR: dig_d = year_bcd;
            default:   dig_d = {hour_bcd, min_bcd};
        endcase

        blank_d = 4'b0000;
`ifdef DISP_LEADING_ZERO_BLANK_EN
        if ((page_d != PAGE_YEAR) && (dig_d[15:12] == 4'd0)) begin
            blank_d[3] = 1'b1;
        end
`endif
        if ((mode_d == MODE_EDIT) && blink_d) begin
            blank_d = blank_d | (edit_field ? 4'b0011 : 4'b1100);
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= MODE_AUTO;
            page_q  <= PAGE_TIME;
            blink_q <= 1'b0;
            dig_q   <= 16'h0000;
            blank_q <= 4'b0000;
        end else begin
            mode_q  <= mode_d;
            page_q  <= page_d;
            blink_q <= blink_d;
            dig_q   <= dig_d;
            blank_q <= blank_d;
        end
    end

    assign dig3  = dig_q[15:12];
    assign dig2  = dig_q[11:8];
    assign dig1  = dig_q[7:4];
    assign dig0  = dig_q[3:0];
    assign blank = blank_q;
    assign page  = page_q;
    assign mode  = mode_q;

endmodule
